// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: bus widths and FSM state encoding.
package wb_arbiter_pkg;

    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 32;
    localparam int SEL_WIDTH = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Width of a master index; a single-master build still needs one bit
    function automatic int idx_width(input int num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: finds the first requester strictly after
// the last-granted pointer, wrapping around, and returns it one-hot and as an index.
module wb_rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_WIDTH   = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_WIDTH-1:0]   ptr,
    output logic [NUM_MASTERS-1:0] pick,
    output logic [IDX_WIDTH-1:0]   pick_idx,
    output logic                   valid
);

    logic [IDX_WIDTH-1:0] cand;

    // Walk the candidates from ptr+1 upward; the first active request wins
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_WIDTH'((int'(ptr) + k) % NUM_MASTERS);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                pick[cand]  = 1'b1;
                pick_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone bus arbiter. Grants whole CYC-held bus cycles to one of
// NUM_MASTERS masters, muxes the winner onto the shared bus and routes ACK/ERR back.
// Optional feature: define WB_ARB_TIMEOUT_EN to abort strobes the slave leaves
// unanswered for TIMEOUT_CYCLES cycles with a one-cycle ERR to the granted master.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_MASTERS-1:0]           m_cyc_i,
    input  logic [NUM_MASTERS-1:0]           m_stb_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic                             s_cyc_o,
    output logic                             s_stb_o,
    output logic                             s_we_o,
    output logic [ADR_WIDTH-1:0]             s_adr_o,
    output logic [DAT_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]             s_sel_o,
    input  logic                             s_ack_i,
    input  logic                             s_err_i,
    output logic [NUM_MASTERS-1:0]           gnt_o
);

    localparam int IDX_WIDTH = idx_width(NUM_MASTERS);

    arb_state_t             state;
    logic [IDX_WIDTH-1:0]   last_ptr;
    logic [IDX_WIDTH-1:0]   gnt_idx;
    logic [NUM_MASTERS-1:0] pick;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic                   pick_valid;
    logic                   stb_raw;
    logic                   timeout_hit;

    wb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_picker (
        .req      (m_cyc_i),
        .ptr      (last_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Arbitration FSM: pick a winner in IDLE, hold the grant until its CYC drops
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ARB_IDLE;
            gnt_o    <= '0;
            gnt_idx  <= '0;
            last_ptr <= IDX_WIDTH'(NUM_MASTERS - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_o   <= pick;
                        gnt_idx <= pick_idx;
                        state   <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!m_cyc_i[gnt_idx]) begin
                        last_ptr <= gnt_idx;
                        gnt_o    <= '0;
                        state    <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt_o <= '0;
                end
            endcase
        end
    end

    // Steer the granted master onto the bus; the bus is left at zero while idle
    always_comb begin
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (state == ARB_GRANT) begin
            s_cyc_o = m_cyc_i[gnt_idx] & gnt_o[gnt_idx];
            stb_raw = m_stb_i[gnt_idx];
            s_we_o  = m_we_i[gnt_idx];
            s_adr_o = m_adr_i[int'(gnt_idx)*ADR_WIDTH +: ADR_WIDTH];
            s_dat_o = m_dat_i[int'(gnt_idx)*DAT_WIDTH +: DAT_WIDTH];
            s_sel_o = m_sel_i[int'(gnt_idx)*SEL_WIDTH +: SEL_WIDTH];
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 stalled;

    assign stalled     = (state == ARB_GRANT) && stb_raw && !s_ack_i && !s_err_i;
    assign timeout_hit = stalled && (stall_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Count unanswered strobe cycles; any response, the end of the grant or a timeout restarts it
    always_ff @(posedge clk_i) begin
        if (rst_i || state != ARB_GRANT || s_ack_i || s_err_i || timeout_hit) begin
            stall_cnt <= '0;
        end else if (stalled) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign s_stb_o = stb_raw & ~timeout_hit;
    assign m_ack_o = {NUM_MASTERS{s_ack_i}} & gnt_o;
    assign m_err_o = ({NUM_MASTERS{s_err_i}} | {NUM_MASTERS{timeout_hit}}) & gnt_o;

endmodule
